// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences one instruction
// over 3-5 states on a shared memory port and keeps cycle/retire counters.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             retire;
  logic [2:0]       funct_alu;
  logic             funct_ok;

  // R-type funct decode, shared by next-state and output logic
  always_comb begin
    funct_alu = 3'b000;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = funct_ok ? S_ALUWB : S_FETCH;
      S_ALUWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BEQ:    begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      default:  state_d = S_FETCH;
    endcase
    cycle_d = cycle_q + CNT_W'(1);
    instr_d = retire ? instr_q + CNT_W'(1) : instr_q;
  end

  // Outputs are held quiet while reset is asserted so no access leaks out.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = 3'b010;
          ir_write    = mem_ready;
          pc_en       = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = 3'b010;
          illegal     = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = 3'b010;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = funct_alu;
          illegal     = !funct_ok;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          pc_src      = 2'b01;
          pc_en       = zero;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// its state sequence and checks enables, counters, reset and counter wrap.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_en, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_control;
  logic        reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  logic        m4_req, m4_we, m4_iord, m4_irw, m4_pcen, m4_srca;
  logic [1:0]  m4_pcsrc, m4_srcb;
  logic [2:0]  m4_aluc;
  logic        m4_rdst, m4_m2r, m4_rw, m4_ill;
  logic [3:0]  m4_state;
  logic [3:0]  m4_cyc, m4_ins;

  logic [31:0] exp_cyc, exp_ins;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state),
    .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(m4_req), .mem_we(m4_we), .iord(m4_iord), .ir_write(m4_irw), .pc_en(m4_pcen),
    .pc_src(m4_pcsrc), .alu_src_a(m4_srca), .alu_src_b(m4_srcb), .alu_control(m4_aluc),
    .reg_dst(m4_rdst), .mem_to_reg(m4_m2r), .reg_write(m4_rw), .state(m4_state),
    .illegal(m4_ill), .cycle_count(m4_cyc), .instr_count(m4_ins)
  );

  // Advance one clock; the expected cycle counter follows the reset rule.
  task automatic tick();
    @(posedge clk);
    if (rst) begin exp_cyc = 0; exp_ins = 0; end
    else exp_cyc = exp_cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst4 = 1; op = 6'b0; funct = 6'b0; zero = 0; mem_ready = 0;
    tick(); tick();
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    tests++; if (cycle_count !== 0 || instr_count !== 0) begin fails++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_count, instr_count); end
    tests++; if (mem_req !== 0 || illegal !== 0) begin fails++; $display("FAIL reset_outputs mem_req=%b illegal=%b exp=0/0", mem_req, illegal); end
    rst = 0;
  endtask

  task automatic test_addi();
    op = 6'b001000; mem_ready = 1; #1;
    tests++; if ({mem_req, iord, ir_write, pc_en, alu_src_a, alu_src_b, alu_control} !== 10'b1011_0_01_010) begin
      fails++; $display("FAIL addi_fetch outs=%b exp=1011001010", {mem_req, iord, ir_write, pc_en, alu_src_a, alu_src_b, alu_control}); end
    tick();
    tests++; if (state !== 4'd1 || alu_src_b !== 2'b11 || reg_write !== 0) begin fails++; $display("FAIL addi_decode state=%0d srcb=%b exp=1/11", state, alu_src_b); end
    tick();
    tests++; if (state !== 4'd9 || alu_src_a !== 1 || alu_src_b !== 2'b10 || reg_write !== 0) begin fails++; $display("FAIL addi_ex state=%0d srca=%b srcb=%b rw=%b exp=9/1/10/0", state, alu_src_a, alu_src_b, reg_write); end
    tick();
    tests++; if (state !== 4'd10 || reg_write !== 1 || reg_dst !== 0 || mem_to_reg !== 0) begin fails++; $display("FAIL addi_wb state=%0d rw=%b exp=10/1", state, reg_write); end
    tick(); exp_ins = exp_ins + 1;
    tests++; if (state !== 4'd0 || instr_count !== exp_ins || cycle_count !== 32'd4) begin fails++; $display("FAIL addi_count state=%0d ins=%0d cyc=%0d exp=0/%0d/4", state, instr_count, cycle_count, exp_ins); end
  endtask

  task automatic test_lw_stall();
    logic [31:0] start;
    start = exp_cyc;
    op = 6'b100011; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (state !== 4'd0 || mem_req !== 1 || iord !== 0 || ir_write !== 0 || pc_en !== 0) begin fails++; $display("FAIL lw_fetch_wait%0d state=%0d req=%b irw=%b pcen=%b exp=0/1/0/0", i, state, mem_req, ir_write, pc_en); end
      tick();
    end
    mem_ready = 1; #1;
    tests++; if (state !== 4'd0 || ir_write !== 1 || pc_en !== 1) begin fails++; $display("FAIL lw_fetch_ready irw=%b pcen=%b exp=1/1", ir_write, pc_en); end
    tick(); tick();
    tests++; if (state !== 4'd2 || alu_src_a !== 1 || alu_src_b !== 2'b10) begin fails++; $display("FAIL lw_memadr state=%0d exp=2", state); end
    tick(); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (state !== 4'd3 || mem_req !== 1 || iord !== 1 || mem_we !== 0) begin fails++; $display("FAIL lw_memrd_wait%0d state=%0d req=%b iord=%b we=%b exp=3/1/1/0", i, state, mem_req, iord, mem_we); end
      tick();
    end
    mem_ready = 1; tick();
    tests++; if (state !== 4'd4 || reg_write !== 1 || mem_to_reg !== 1 || reg_dst !== 0) begin fails++; $display("FAIL lw_memwb state=%0d rw=%b m2r=%b exp=4/1/1", state, reg_write, mem_to_reg); end
    tick(); exp_ins = exp_ins + 1;
    tests++; if (state !== 4'd0 || instr_count !== exp_ins || cycle_count !== start + 32'd10 || cycle_count !== exp_cyc) begin fails++; $display("FAIL lw_count ins=%0d cyc=%0d exp=%0d/%0d", instr_count, cycle_count, exp_ins, start + 32'd10); end
  endtask

  task automatic test_beq();
    op = 6'b000100; mem_ready = 1;
    zero = 1; tick(); tick();
    tests++; if (state !== 4'd8 || pc_en !== 1 || pc_src !== 2'b01 || alu_control !== 3'b110) begin fails++; $display("FAIL beq_taken state=%0d pcen=%b pcsrc=%b aluc=%b exp=8/1/01/110", state, pc_en, pc_src, alu_control); end
    tick(); zero = 0; tick(); tick();
    tests++; if (state !== 4'd8 || pc_en !== 0) begin fails++; $display("FAIL beq_not_taken state=%0d pcen=%b exp=8/0", state, pc_en); end
    tick(); exp_ins = exp_ins + 2;
    tests++; if (instr_count !== exp_ins) begin fails++; $display("FAIL beq_count got=%0d exp=%0d", instr_count, exp_ins); end
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b101010; mem_ready = 1;
    tick(); tick();
    tests++; if (state !== 4'd6 || alu_control !== 3'b111 || illegal !== 0 || alu_src_a !== 1 || alu_src_b !== 2'b00) begin fails++; $display("FAIL slt_exec state=%0d aluc=%b ill=%b exp=6/111/0", state, alu_control, illegal); end
    tick();
    tests++; if (state !== 4'd7 || reg_write !== 1 || reg_dst !== 1 || mem_to_reg !== 0) begin fails++; $display("FAIL slt_wb state=%0d rw=%b rdst=%b exp=7/1/1", state, reg_write, reg_dst); end
    tick(); exp_ins = exp_ins + 1;
    funct = 6'b000111; tick(); tick();
    tests++; if (state !== 4'd6 || illegal !== 1 || reg_write !== 0) begin fails++; $display("FAIL badfunct_exec state=%0d ill=%b rw=%b exp=6/1/0", state, illegal, reg_write); end
    tick();
    tests++; if (state !== 4'd0 || illegal !== 0 || instr_count !== exp_ins) begin fails++; $display("FAIL badfunct_after state=%0d ill=%b ins=%0d exp=0/0/%0d", state, illegal, instr_count, exp_ins); end
  endtask

  task automatic test_illegal_op();
    op = 6'b111111; mem_ready = 1;
    tick();
    tests++; if (state !== 4'd1 || illegal !== 1 || {mem_req, ir_write, pc_en, reg_write, mem_we} !== 5'b0) begin fails++; $display("FAIL badop_decode state=%0d ill=%b en=%b exp=1/1/00000", state, illegal, {mem_req, ir_write, pc_en, reg_write, mem_we}); end
    tick();
    tests++; if (state !== 4'd0 || illegal !== 0 || instr_count !== exp_ins) begin fails++; $display("FAIL badop_after state=%0d ill=%b ins=%0d exp=0/0/%0d", state, illegal, instr_count, exp_ins); end
  endtask

  task automatic test_jump();
    op = 6'b000010; mem_ready = 1;
    tick(); tick();
    tests++; if (state !== 4'd11 || pc_en !== 1 || pc_src !== 2'b10) begin fails++; $display("FAIL jump state=%0d pcen=%b pcsrc=%b exp=11/1/10", state, pc_en, pc_src); end
    tick(); exp_ins = exp_ins + 1;
    tests++; if (state !== 4'd0 || instr_count !== exp_ins || cycle_count !== exp_cyc) begin fails++; $display("FAIL jump_count ins=%0d cyc=%0d exp=%0d/%0d", instr_count, cycle_count, exp_ins, exp_cyc); end
  endtask

  task automatic test_reset_mid_access();
    op = 6'b101011; mem_ready = 1;
    tick(); tick(); mem_ready = 0; tick(); #1;
    tests++; if (state !== 4'd5 || mem_req !== 1 || mem_we !== 1 || iord !== 1) begin fails++; $display("FAIL sw_wait state=%0d req=%b we=%b iord=%b exp=5/1/1/1", state, mem_req, mem_we, iord); end
    tick();
    tests++; if (state !== 4'd5 || instr_count !== exp_ins) begin fails++; $display("FAIL sw_hold state=%0d ins=%0d exp=5/%0d", state, instr_count, exp_ins); end
    rst = 1; mem_ready = 1; tick();
    tests++; if (state !== 4'd0 || mem_req !== 0 || cycle_count !== 0 || instr_count !== 0) begin fails++; $display("FAIL rst_mid state=%0d req=%b cyc=%0d ins=%0d exp=0/0/0/0", state, mem_req, cycle_count, instr_count); end
    rst = 0;
  endtask

  task automatic test_wrap();
    op = 6'b001000; mem_ready = 1;
    rst4 = 0;
    for (int i = 0; i < 15; i++) tick();
    tests++; if (m4_cyc !== 4'd15) begin fails++; $display("FAIL wrap_15 got=%0d exp=15", m4_cyc); end
    tick();
    tests++; if (m4_cyc !== 4'd0) begin fails++; $display("FAIL wrap_0 got=%0d exp=0", m4_cyc); end
    tick();
    tests++; if (m4_cyc !== 4'd1 || m4_ins !== 4'd4) begin fails++; $display("FAIL wrap_17 cyc=%0d ins=%0d exp=1/4", m4_cyc, m4_ins); end
  endtask

  initial begin
    exp_cyc = 0; exp_ins = 0;
    test_reset();
    test_addi();
    test_lw_stall();
    test_beq();
    test_rtype();
    test_illegal_op();
    test_jump();
    test_reset_mid_access();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
